counter_arbiter: RTL

Round-robin controller that shares one WIDTH-bit up-counter between NUM_REQ requesters. Each requester asks for a count run of a given length. The arbiter grants one requester, clears the shared counter, enables it until the count reaches the requested length, then pulses done to that requester. It sits between the requesting blocks and the counter's clear/enable inputs, and observes the counter's count output.

---
 rtl/counter_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one up-counter among NUM_REQ requesters.
// Optional run watchdog enabled by defining COUNTER_ARB_TIMEOUT_EN.
module counter_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] len,
    input  logic [WIDTH-1:0]         cnt_val,
    output logic                     cnt_clr,
    output logic                     cnt_en,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     err
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state_q,   state_d;
    logic [IDX_W-1:0]   owner_q,   owner_d;
    logic [IDX_W-1:0]   rr_last_q, rr_last_d;
    logic [WIDTH-1:0]   len_q,     len_d;
    logic [NUM_REQ-1:0] gnt_q,     gnt_d;
    logic [NUM_REQ-1:0] done_q,    done_d;
    logic               cnt_clr_q, cnt_clr_d;
    logic               busy_q,    busy_d;

    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;

`ifdef COUNTER_ARB_TIMEOUT_EN
    localparam int unsigned      WD_W    = WIDTH + 2;
    // Last RUN cycle allowed before the watchdog forces completion
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'((1 << WIDTH) + 1);

    logic [WD_W-1:0] wd_q,  wd_d;
    logic            err_q, err_d;
`endif

    // Round-robin search starting just above the last owner
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((32'(rr_last_q) + i) % NUM_REQ);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        len_d     = len_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        cnt_clr_d = 1'b0;
`ifdef COUNTER_ARB_TIMEOUT_EN
        err_d     = 1'b0;
        wd_d      = wd_q;
        if (state_q == S_CLEAR) begin
            wd_d = '0;
        end else if (state_q == S_RUN) begin
            wd_d = wd_q + WD_W'(1);
        end
`endif
        case (state_q)
            S_IDLE: begin
                gnt_d = '0;
                if (pick_vld) begin
                    state_d   = S_CLEAR;
                    owner_d   = pick_idx;
                    rr_last_d = pick_idx;
                    len_d     = len[pick_idx*WIDTH +: WIDTH];
                    gnt_d     = NUM_REQ'(1) << pick_idx;
                    cnt_clr_d = 1'b1;
                end
            end
            S_CLEAR: begin
                if (!req[owner_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!req[owner_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end else if (cnt_val == len_q) begin
                    state_d = S_DONE;
                    done_d  = NUM_REQ'(1) << owner_q;
                end
`ifdef COUNTER_ARB_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    state_d = S_DONE;
                    done_d  = NUM_REQ'(1) << owner_q;
                    err_d   = 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            owner_q   <= '0;
            rr_last_q <= IDX_W'(NUM_REQ - 1);
            len_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            cnt_clr_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef COUNTER_ARB_TIMEOUT_EN
            wd_q      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            len_q     <= len_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            cnt_clr_q <= cnt_clr_d;
            busy_q    <= busy_d;
`ifdef COUNTER_ARB_TIMEOUT_EN
            wd_q      <= wd_d;
            err_q     <= err_d;
`endif
        end
    end

    // Enable drops in the very cycle the counter matches the target
    assign cnt_en  = (state_q == S_RUN) && (cnt_val != len_q);
    assign cnt_clr = cnt_clr_q;
    assign gnt     = gnt_q;
    assign done    = done_q;
    assign busy    = busy_q;
`ifdef COUNTER_ARB_TIMEOUT_EN
    assign err     = err_q;
`else
    assign err     = 1'b0;
`endif

endmodule
